// File: rtl/psram_async_ctrl.sv
// Single-transaction controller for a 16-bit asynchronous CellularRAM.
// Host side is a go/done master of width DATA_W (8/16/32); 32-bit requests
// are split into two back-to-back halfword device cycles. Every device pin
// and host output is a register, so the pins are glitch-free.
//
// Handshake: go is sampled only in IDLE; once taken, busy rises on the next
// cycle and stays high until the single-cycle done pulse, during which err
// and data_o are valid. go seen in any other state is dropped, not queued.
module psram_async_ctrl #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 32,
   parameter int ACCESS_CYC  = 4,
   parameter int RECOVER_CYC = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [DATA_W/8-1:0] be,
   input  logic                write_enable,
   input  logic                go,
   output logic [DATA_W-1:0]   data_o,
   output logic                done,
   output logic                busy,
   output logic                err,
   output logic [25:0]         ram_addr,
   inout  wire  [15:0]         ram_data,
   output logic                ram_oe,
   output logic                ram_we,
   output logic                ram_ce,
   output logic                ram_ub,
   output logic                ram_lb,
   output logic                ram_clk,
   output logic                ram_adv,
   output logic                ram_cre,
   input  logic                ram_wait
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RECOVER,
      S_DONE
   } state_t;

   // Index of the final halfword of a request (1 only for 32-bit hosts).
   localparam logic LAST_HW = (DATA_W == 32);

   state_t      state;
   logic [15:0] cnt;       // remaining cycles in ACCESS / RECOVER
   logic        hw;        // current halfword index
   logic [25:0] base_hw;   // halfword address of the first device cycle
   logic        a0_r;
   logic [3:0]  be_r;
   logic [31:0] wd_r;
   logic        wr_r;
   logic [31:0] rbuf;      // read data assembled across halfwords
   logic        dq_oe;
   logic [15:0] dq_out;

   // Host inputs widened to the 32-bit internal datapath.
   logic [3:0]  be_w;
   logic [31:0] d_w;
   logic [26:0] a_w;
   logic        misal;
   logic [17:0] go_lanes;
   logic [17:0] nx_lanes;
   logic [7:0]  rd_byte;
   logic        unused_sig;

   assign be_w = 4'(be);
   assign d_w  = 32'(data_i);
   assign a_w  = 27'(addr);

   // Synchronous-mode pins are parked; ram_wait has no meaning here.
   assign ram_clk = 1'b0;
   assign ram_adv = 1'b0;
   assign ram_cre = 1'b0;
   assign unused_sig = ^{ram_wait, addr, rbuf};

   assign ram_data = dq_oe ? dq_out : 16'hzzzz;

   // Returns {ub_n, lb_n, bus data} for one halfword of a request.
   function automatic logic [17:0] lane_map(input logic a0, input logic wr,
                                            input logic [3:0] b, input logic [31:0] d,
                                            input logic idx);
      logic        ub_n;
      logic        lb_n;
      logic [15:0] dq;
      ub_n = 1'b0;
      lb_n = 1'b0;
      dq   = d[15:0];
      if (DATA_W == 8) begin
         ub_n = ~a0;
         lb_n = a0;
         dq   = {d[7:0], d[7:0]};
      end else if (idx) begin
         dq = d[31:16];
         if (wr) begin
            ub_n = ~b[3];
            lb_n = ~b[2];
         end
      end else if (wr) begin
         ub_n = ~b[1];
         lb_n = ~b[0];
      end
      return {ub_n, lb_n, dq};
   endfunction

   assign go_lanes = lane_map(a_w[0], write_enable, be_w, d_w, 1'b0);
   assign nx_lanes = lane_map(a0_r, wr_r, be_r, wd_r, 1'b1);
   assign rd_byte  = a0_r ? ram_data[15:8] : ram_data[7:0];

   // Misalignment depends only on the host width.
   always_comb begin
      misal = 1'b0;
      if (DATA_W == 16)      misal = a_w[0];
      else if (DATA_W == 32) misal = |a_w[1:0];
   end

   // Main FSM: sequences setup/access/recover per halfword, drives all pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= 16'd0;
         hw       <= 1'b0;
         base_hw  <= 26'd0;
         a0_r     <= 1'b0;
         be_r     <= 4'd0;
         wd_r     <= 32'd0;
         wr_r     <= 1'b0;
         rbuf     <= 32'd0;
         dq_oe    <= 1'b0;
         dq_out   <= 16'd0;
         data_o   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         ram_addr <= 26'd0;
         ram_ce   <= 1'b1;
         ram_oe   <= 1'b1;
         ram_we   <= 1'b1;
         ram_ub   <= 1'b1;
         ram_lb   <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (go) begin
                  base_hw <= a_w[26:1];
                  a0_r    <= a_w[0];
                  be_r    <= be_w;
                  wd_r    <= d_w;
                  wr_r    <= write_enable;
                  hw      <= 1'b0;
                  if (misal) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= S_SETUP;
                     busy     <= 1'b1;
                     ram_ce   <= 1'b0;
                     ram_addr <= a_w[26:1];
                     ram_ub   <= go_lanes[17];
                     ram_lb   <= go_lanes[16];
                     dq_out   <= go_lanes[15:0];
                     dq_oe    <= write_enable;
                  end
               end
            end
            S_SETUP: begin
               state <= S_ACCESS;
               cnt   <= 16'(ACCESS_CYC - 1);
               if (wr_r) ram_we <= 1'b0;
               else      ram_oe <= 1'b0;
            end
            S_ACCESS: begin
               if (cnt == 16'd0) begin
                  if (!wr_r) begin
                     if (DATA_W == 8) rbuf[7:0]   <= rd_byte;
                     else if (hw)     rbuf[31:16] <= ram_data;
                     else             rbuf[15:0]  <= ram_data;
                  end
                  state  <= S_RECOVER;
                  cnt    <= 16'(RECOVER_CYC - 1);
                  ram_ce <= 1'b1;
                  ram_oe <= 1'b1;
                  ram_we <= 1'b1;
                  ram_ub <= 1'b1;
                  ram_lb <= 1'b1;
                  dq_oe  <= 1'b0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_RECOVER: begin
               if (cnt != 16'd0) begin
                  cnt <= cnt - 16'd1;
               end else if (hw == LAST_HW) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  err   <= 1'b0;
                  if (!wr_r) data_o <= rbuf[DATA_W-1:0];
               end else begin
                  state    <= S_SETUP;
                  hw       <= 1'b1;
                  ram_ce   <= 1'b0;
                  ram_addr <= base_hw + 26'd1;
                  ram_ub   <= nx_lanes[17];
                  ram_lb   <= nx_lanes[16];
                  dq_out   <= nx_lanes[15:0];
                  dq_oe    <= wr_r;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               err   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Directed bench for psram_async_ctrl: three instances (8/16/32-bit hosts),
// each attached to a small behavioural PSRAM, checked against hand values.
module tb_psram_async_ctrl;

   logic clk;
   logic rst_n;
   logic mem_init;

   // Shared stimulus; go is steered to one instance by sel.
   int          sel;
   logic        go;
   logic        wr;
   logic [31:0] tb_addr;
   logic [31:0] tb_data;
   logic [3:0]  tb_be;

   int n_vec;
   int n_bad;

   logic go8, go16, go32;
   assign go8  = go && (sel == 0);
   assign go16 = go && (sel == 1);
   assign go32 = go && (sel == 2);

   logic [7:0]  do8;
   logic [15:0] do16;
   logic [31:0] do32;
   logic        done8, done16, done32, busy8, busy16, busy32, err8, err16, err32;
   logic [25:0] a8, a16, a32;
   wire  [15:0] dq8, dq16, dq32;
   logic        ce8, ce16, ce32, oe8, oe16, oe32, we8, we16, we32;
   logic        ub8, ub16, ub32, lb8, lb16, lb32;
   logic        ck8, ck16, ck32, adv8, adv16, adv32, cre8, cre16, cre32;

   logic [15:0] mem8  [64];
   logic [15:0] mem16 [64];
   logic [15:0] mem32 [64];

   psram_async_ctrl #(.DATA_W(8)) u8 (
      .clk(clk), .rst_n(rst_n), .addr(tb_addr), .data_i(tb_data[7:0]), .be(tb_be[0]),
      .write_enable(wr), .go(go8), .data_o(do8), .done(done8), .busy(busy8), .err(err8),
      .ram_addr(a8), .ram_data(dq8), .ram_oe(oe8), .ram_we(we8), .ram_ce(ce8),
      .ram_ub(ub8), .ram_lb(lb8), .ram_clk(ck8), .ram_adv(adv8), .ram_cre(cre8),
      .ram_wait(1'b0));

   psram_async_ctrl #(.DATA_W(16)) u16 (
      .clk(clk), .rst_n(rst_n), .addr(tb_addr), .data_i(tb_data[15:0]), .be(tb_be[1:0]),
      .write_enable(wr), .go(go16), .data_o(do16), .done(done16), .busy(busy16), .err(err16),
      .ram_addr(a16), .ram_data(dq16), .ram_oe(oe16), .ram_we(we16), .ram_ce(ce16),
      .ram_ub(ub16), .ram_lb(lb16), .ram_clk(ck16), .ram_adv(adv16), .ram_cre(cre16),
      .ram_wait(1'b0));

   psram_async_ctrl #(.DATA_W(32)) u32 (
      .clk(clk), .rst_n(rst_n), .addr(tb_addr), .data_i(tb_data), .be(tb_be),
      .write_enable(wr), .go(go32), .data_o(do32), .done(done32), .busy(busy32), .err(err32),
      .ram_addr(a32), .ram_data(dq32), .ram_oe(oe32), .ram_we(we32), .ram_ce(ce32),
      .ram_ub(ub32), .ram_lb(lb32), .ram_clk(ck32), .ram_adv(adv32), .ram_cre(cre32),
      .ram_wait(1'b0));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- PSRAM models ----------------
   assign dq8  = (!ce8  && !oe8 ) ? mem8 [a8 [5:0]] : 16'hzzzz;
   assign dq16 = (!ce16 && !oe16) ? mem16[a16[5:0]] : 16'hzzzz;
   assign dq32 = (!ce32 && !oe32) ? mem32[a32[5:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) begin
            mem8[i]  <= 16'h0;
            mem16[i] <= 16'h0;
            mem32[i] <= 16'h0;
         end
         mem8[1]   <= 16'h1234;
         mem32[4]  <= 16'hAAAA;
         mem32[5]  <= 16'hBBBB;
         mem32[62] <= 16'h1111;
         mem32[63] <= 16'h2222;
      end else begin
         if (!ce8 && !we8) begin
            if (!lb8) mem8[a8[5:0]][7:0]  <= dq8[7:0];
            if (!ub8) mem8[a8[5:0]][15:8] <= dq8[15:8];
         end
         if (!ce16 && !we16) begin
            if (!lb16) mem16[a16[5:0]][7:0]  <= dq16[7:0];
            if (!ub16) mem16[a16[5:0]][15:8] <= dq16[15:8];
         end
         if (!ce32 && !we32) begin
            if (!lb32) mem32[a32[5:0]][7:0]  <= dq32[7:0];
            if (!ub32) mem32[a32[5:0]][15:8] <= dq32[15:8];
         end
      end
   end

   // ---------------- monitor mux ----------------
   logic        m_ce, m_oe, m_we, m_ub, m_lb, m_done, m_busy, m_err, m_ck, m_adv, m_cre;
   logic [25:0] m_addr;
   logic [15:0] m_dq;
   logic [31:0] m_do;

   always_comb begin
      m_ce = ce8; m_oe = oe8; m_we = we8; m_ub = ub8; m_lb = lb8;
      m_done = done8; m_busy = busy8; m_err = err8; m_addr = a8; m_dq = dq8;
      m_do = 32'(do8); m_ck = ck8; m_adv = adv8; m_cre = cre8;
      case (sel)
         1: begin
            m_ce = ce16; m_oe = oe16; m_we = we16; m_ub = ub16; m_lb = lb16;
            m_done = done16; m_busy = busy16; m_err = err16; m_addr = a16; m_dq = dq16;
            m_do = 32'(do16); m_ck = ck16; m_adv = adv16; m_cre = cre16;
         end
         2: begin
            m_ce = ce32; m_oe = oe32; m_we = we32; m_ub = ub32; m_lb = lb32;
            m_done = done32; m_busy = busy32; m_err = err32; m_addr = a32; m_dq = dq32;
            m_do = do32; m_ck = ck32; m_adv = adv32; m_cre = cre32;
         end
         default: ;
      endcase
   end

   // ---------------- driver: one transaction, recorded ----------------
   int          r_lat, r_nhw, r_oe, r_busy;
   logic        r_err, r_pulse;
   logic [31:0] r_data;
   logic [25:0] r_addr [2];
   logic        r_ub [2];
   logic        r_lb [2];
   logic [15:0] r_dq [2];
   int          r_we [2];

   // Called at a negedge; issues go for one edge and watches up to 50 cycles.
   task automatic run(input int s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
      logic prev_ce;
      sel = s; wr = w; tb_addr = a; tb_data = d; tb_be = b; go = 1'b1;
      r_lat = 0; r_nhw = 0; r_oe = 0; r_busy = 0; r_err = 1'b0; r_data = 32'h0;
      for (int k = 0; k < 2; k++) begin
         r_addr[k] = 26'h0; r_ub[k] = 1'b1; r_lb[k] = 1'b1; r_dq[k] = 16'h0; r_we[k] = 0;
      end
      prev_ce = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (!m_ce && prev_ce) begin
            if (r_nhw < 2) begin
               r_addr[r_nhw] = m_addr; r_ub[r_nhw] = m_ub; r_lb[r_nhw] = m_lb;
            end
            r_nhw++;
         end
         if (!m_we && r_nhw > 0 && r_nhw <= 2) begin
            r_we[r_nhw-1]++;
            r_dq[r_nhw-1] = m_dq;
         end
         if (!m_oe) r_oe++;
         if (m_busy) r_busy++;
         prev_ce = m_ce;
         if (m_done) begin
            r_lat = n; r_err = m_err; r_data = m_do;
            break;
         end
      end
      @(negedge clk);
      r_pulse = m_done;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_vec++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL rst_done[%0d]: got %b want 0", s, m_done); end
         n_vec++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy[%0d]: got %b want 0", s, m_busy); end
         n_vec++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL rst_err[%0d]: got %b want 0", s, m_err); end
         n_vec++; if (m_do !== 32'h0) begin n_bad++; $display("FAIL rst_data_o[%0d]: got %h want 0", s, m_do); end
         n_vec++; if (m_addr !== 26'h0) begin n_bad++; $display("FAIL rst_ram_addr[%0d]: got %h want 0", s, m_addr); end
         n_vec++; if ({m_ce, m_oe, m_we, m_ub, m_lb} !== 5'h1F) begin n_bad++; $display("FAIL rst_ctrl[%0d]: got %b want 11111", s, {m_ce, m_oe, m_we, m_ub, m_lb}); end
         n_vec++; if ({m_ck, m_adv, m_cre} !== 3'b000) begin n_bad++; $display("FAIL rst_tied[%0d]: got %b want 000", s, {m_ck, m_adv, m_cre}); end
      end
      @(negedge clk);
   endtask

   task automatic test_w16();
      run(1, 1'b1, 32'h2, 32'hBEEF, 4'b0011);
      n_vec++; if (r_lat !== 7) begin n_bad++; $display("FAIL w16_wr_lat: got %0d want 7", r_lat); end
      n_vec++; if (r_nhw !== 1 || r_addr[0] !== 26'h1) begin n_bad++; $display("FAIL w16_wr_addr: got n=%0d a=%h want n=1 a=1", r_nhw, r_addr[0]); end
      n_vec++; if ({r_ub[0], r_lb[0]} !== 2'b00) begin n_bad++; $display("FAIL w16_wr_lanes: got %b want 00", {r_ub[0], r_lb[0]}); end
      n_vec++; if (r_we[0] !== 4 || r_oe !== 0) begin n_bad++; $display("FAIL w16_wr_strobe: got we=%0d oe=%0d want 4 0", r_we[0], r_oe); end
      n_vec++; if (r_dq[0] !== 16'hBEEF) begin n_bad++; $display("FAIL w16_wr_bus: got %h want beef", r_dq[0]); end
      n_vec++; if (r_busy !== 6 || r_pulse !== 1'b0 || r_err !== 1'b0) begin n_bad++; $display("FAIL w16_wr_hs: got busy=%0d pulse=%b err=%b want 6 0 0", r_busy, r_pulse, r_err); end
      n_vec++; if (mem16[1] !== 16'hBEEF) begin n_bad++; $display("FAIL w16_wr_mem: got %h want beef", mem16[1]); end
      run(1, 1'b0, 32'h2, 32'h0, 4'b0000);
      n_vec++; if (r_lat !== 7 || r_err !== 1'b0) begin n_bad++; $display("FAIL w16_rd_lat: got %0d err=%b want 7 0", r_lat, r_err); end
      n_vec++; if (r_data !== 32'hBEEF) begin n_bad++; $display("FAIL w16_rd_data: got %h want beef", r_data); end
      n_vec++; if (r_oe !== 4 || {r_ub[0], r_lb[0]} !== 2'b00) begin n_bad++; $display("FAIL w16_rd_strobe: got oe=%0d lanes=%b want 4 00", r_oe, {r_ub[0], r_lb[0]}); end
   endtask

   task automatic test_w8();
      run(0, 1'b1, 32'h3, 32'h5A, 4'b0001);
      n_vec++; if (r_lat !== 7 || r_addr[0] !== 26'h1) begin n_bad++; $display("FAIL w8_wr: got lat=%0d a=%h want 7 1", r_lat, r_addr[0]); end
      n_vec++; if ({r_ub[0], r_lb[0]} !== 2'b01) begin n_bad++; $display("FAIL w8_wr_lanes: got %b want 01", {r_ub[0], r_lb[0]}); end
      n_vec++; if (r_dq[0][15:8] !== 8'h5A) begin n_bad++; $display("FAIL w8_wr_bus: got %h want 5a", r_dq[0][15:8]); end
      n_vec++; if (mem8[1] !== 16'h5A34) begin n_bad++; $display("FAIL w8_wr_mem: got %h want 5a34", mem8[1]); end
      run(0, 1'b0, 32'h3, 32'h0, 4'b0000);
      n_vec++; if (r_data !== 32'h5A) begin n_bad++; $display("FAIL w8_rd_hi: got %h want 5a", r_data); end
      run(0, 1'b0, 32'h2, 32'h0, 4'b0000);
      n_vec++; if (r_data !== 32'h34) begin n_bad++; $display("FAIL w8_rd_lo: got %h want 34", r_data); end
      n_vec++; if ({r_ub[0], r_lb[0]} !== 2'b10) begin n_bad++; $display("FAIL w8_rd_lanes: got %b want 10", {r_ub[0], r_lb[0]}); end
   endtask

   task automatic test_w32();
      run(2, 1'b1, 32'h8, 32'h12345678, 4'b0101);
      n_vec++; if (r_lat !== 13 || r_busy !== 12) begin n_bad++; $display("FAIL w32_wr_lat: got %0d busy=%0d want 13 12", r_lat, r_busy); end
      n_vec++; if (r_nhw !== 2 || r_addr[0] !== 26'h4 || r_addr[1] !== 26'h5) begin n_bad++; $display("FAIL w32_wr_addr: got n=%0d %h %h want 2 4 5", r_nhw, r_addr[0], r_addr[1]); end
      n_vec++; if ({r_ub[0], r_lb[0], r_ub[1], r_lb[1]} !== 4'b1010) begin n_bad++; $display("FAIL w32_wr_lanes: got %b want 1010", {r_ub[0], r_lb[0], r_ub[1], r_lb[1]}); end
      n_vec++; if (r_dq[0][7:0] !== 8'h78 || r_dq[1][7:0] !== 8'h34) begin n_bad++; $display("FAIL w32_wr_bus: got %h %h want 78 34", r_dq[0][7:0], r_dq[1][7:0]); end
      n_vec++; if (r_we[0] !== 4 || r_we[1] !== 4) begin n_bad++; $display("FAIL w32_wr_we: got %0d %0d want 4 4", r_we[0], r_we[1]); end
      n_vec++; if (mem32[4] !== 16'hAA78 || mem32[5] !== 16'hBB34) begin n_bad++; $display("FAIL w32_wr_mem: got %h %h want aa78 bb34", mem32[4], mem32[5]); end
      run(2, 1'b0, 32'h8, 32'h0, 4'b0000);
      n_vec++; if (r_data !== 32'hBB34AA78 || r_lat !== 13) begin n_bad++; $display("FAIL w32_rd: got %h lat=%0d want bb34aa78 13", r_data, r_lat); end
      n_vec++; if (r_oe !== 8) begin n_bad++; $display("FAIL w32_rd_oe: got %0d want 8", r_oe); end
   endtask

   task automatic test_misaligned();
      run(2, 1'b0, 32'h6, 32'h0, 4'b0000);
      n_vec++; if (r_lat !== 1 || r_err !== 1'b1) begin n_bad++; $display("FAIL mis32_done: got lat=%0d err=%b want 1 1", r_lat, r_err); end
      n_vec++; if (r_nhw !== 0 || r_busy !== 0) begin n_bad++; $display("FAIL mis32_quiet: got ce=%0d busy=%0d want 0 0", r_nhw, r_busy); end
      n_vec++; if (r_data !== 32'hBB34AA78 || r_pulse !== 1'b0) begin n_bad++; $display("FAIL mis32_data: got %h pulse=%b want bb34aa78 0", r_data, r_pulse); end
      run(1, 1'b1, 32'h1, 32'h5555, 4'b0011);
      n_vec++; if (r_lat !== 1 || r_err !== 1'b1 || r_nhw !== 0) begin n_bad++; $display("FAIL mis16: got lat=%0d err=%b ce=%0d want 1 1 0", r_lat, r_err, r_nhw); end
      n_vec++; if (mem16[0] !== 16'h0) begin n_bad++; $display("FAIL mis16_mem: got %h want 0", mem16[0]); end
   endtask

   task automatic test_wrap();
      run(2, 1'b0, 32'hFFFFFFFC, 32'h0, 4'b0000);
      n_vec++; if (r_addr[0] !== 26'h3FFFFFE || r_addr[1] !== 26'h3FFFFFF) begin n_bad++; $display("FAIL wrap_addr: got %h %h want 3fffffe 3ffffff", r_addr[0], r_addr[1]); end
      n_vec++; if (r_data !== 32'h22221111 || r_err !== 1'b0) begin n_bad++; $display("FAIL wrap_data: got %h err=%b want 22221111 0", r_data, r_err); end
   endtask

   task automatic test_back_to_back();
      int   q[$];
      logic prev_done;
      logic dbl;
      sel = 1; wr = 1'b0; tb_addr = 32'h2; tb_data = 32'h0; tb_be = 4'b0; go = 1'b1;
      prev_done = 1'b0; dbl = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         @(negedge clk);
         if (m_done) q.push_back(n);
         if (m_done && prev_done) dbl = 1'b1;
         prev_done = m_done;
      end
      go = 1'b0;
      n_vec++; if (q.size() !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", q.size()); end
      for (int k = 0; k < 4 && k < q.size(); k++) begin
         n_vec++; if (q[k] !== 7 + 8 * k) begin n_bad++; $display("FAIL b2b_pos[%0d]: got %0d want %0d", k, q[k], 7 + 8 * k); end
      end
      n_vec++; if (dbl !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse: got wide done want single"); end
      n_vec++; if (m_do !== 32'hBEEF) begin n_bad++; $display("FAIL b2b_data: got %h want beef", m_do); end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      sel = 1; wr = 1'b1; tb_addr = 32'h4; tb_data = 32'h1111; tb_be = 4'b0011; go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (m_we !== 1'b0) begin n_bad++; $display("FAIL rmid_pre_we: got %b want 0", m_we); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (m_ce !== 1'b1 || m_we !== 1'b1) begin n_bad++; $display("FAIL rmid_ctrl: got ce=%b we=%b want 1 1", m_ce, m_we); end
      n_vec++; if (m_busy !== 1'b0 || m_done !== 1'b0) begin n_bad++; $display("FAIL rmid_hs: got busy=%b done=%b want 0 0", m_busy, m_done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(1, 1'b0, 32'h2, 32'h0, 4'b0000);
      n_vec++; if (r_lat !== 7 || r_data !== 32'hBEEF) begin n_bad++; $display("FAIL rmid_after: got lat=%0d data=%h want 7 beef", r_lat, r_data); end
   endtask

   // ---------------- sequencer ----------------
   initial begin
      n_vec = 0; n_bad = 0;
      rst_n = 1'b0; mem_init = 1'b1; go = 1'b0; sel = 0; wr = 1'b0;
      tb_addr = 32'h0; tb_data = 32'h0; tb_be = 4'h0;
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_w16();
      test_w8();
      test_w32();
      test_misaligned();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Absolute bound in case a wait never resolves.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
